// File: rtl/fir_stream_pkg.sv
// Shared sample type and saturating gain helper for the FIR output stream.
package fir_stream_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned SAT_W    = SAMPLE_W + 3;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    localparam int SAT_MAX_I = 2 ** (SAMPLE_W - 1) - 1;
    localparam logic signed [SAT_W-1:0] SAT_MAX = SAT_W'(SAT_MAX_I);
    localparam logic signed [SAT_W-1:0] SAT_MIN = SAT_W'(-SAT_MAX_I - 1);

    // Left shift by 0..3 in a widened signed intermediate, then clamp to sample range.
    function automatic sample_t sat_shift(input sample_t s, input logic [1:0] shift);
        logic signed [SAT_W-1:0] wide;
        wide = SAT_W'(s) <<< shift;
        if (wide > SAT_MAX) begin
            return {1'b0, {(SAMPLE_W-1){1'b1}}};
        end else if (wide < SAT_MIN) begin
            return {1'b1, {(SAMPLE_W-1){1'b0}}};
        end
        return wide[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Register-based synchronous FIFO; read data is the entry at the registered read pointer.
module sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A full FIFO still accepts a push when the same cycle frees an entry.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
            end
        end
    end

endmodule

// File: rtl/fir_out_decimator.sv
// FIR output stage: drops warm-up samples, applies saturating gain, decimates, and buffers
// kept samples in a FIFO behind a valid/ready stream.
module fir_out_decimator
    import fir_stream_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned DECIM      = 4,
    parameter int unsigned WARMUP     = 3,
    parameter int unsigned GAIN_SHIFT = 0,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic signed [DATA_W-1:0]       in_data,
    input  logic                           in_en,
    output logic signed [DATA_W-1:0]       out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           overflow,
    input  logic                           clr_overflow,
    output logic [$clog2(FIFO_DEPTH):0]    fill_level
);

    localparam int unsigned WARM_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam int unsigned PH_W   = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [WARM_W-1:0] warm_q, warm_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic              ovf_q, ovf_d;
    logic              warm_done;
    logic              keep;
    logic              push;
    logic              pop;
    logic              drop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rdata;
    logic [DATA_W-1:0] gained;

    assign warm_done = (warm_q == WARM_W'(WARMUP));
    assign gained    = DATA_W'(sat_shift(sample_t'(in_data), 2'(GAIN_SHIFT)));

    // Counters only move on accepted samples; phase starts once warm-up has saturated.
    always_comb begin
        warm_d  = warm_q;
        phase_d = phase_q;
        keep    = 1'b0;
        if (in_en) begin
            if (!warm_done) begin
                warm_d = warm_q + WARM_W'(1);
            end else begin
                keep    = (phase_q == '0);
                phase_d = (phase_q == PH_W'(DECIM - 1)) ? '0 : phase_q + PH_W'(1);
            end
        end
    end

    assign pop  = !fifo_empty && out_ready;
    assign push = keep && (!fifo_full || pop);
    assign drop = keep && fifo_full && !pop;

    // Setting wins over a same-cycle clear so no drop event is ever lost.
    always_comb begin
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_overflow) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            warm_q  <= '0;
            phase_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            warm_q  <= warm_d;
            phase_q <= phase_d;
            ovf_q   <= ovf_d;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (gained),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fill_level)
    );

    assign out_data  = fifo_rdata;
    assign out_valid = !fifo_empty;
    assign overflow  = ovf_q;

endmodule
